credit_sink: RTL

Terminal consumer of the credit-based latency-insensitive channel. Sits directly downstream of a credit-wrapped FIR stage and receives its tagged output words (bit 0 = pearl valid tag, upper bits = sample). It buffers words in an N_CREDITS-deep FIFO, discards untagged words, and presents tagged samples on a ready/valid port for the host or capture logic. It returns one credit pulse upstream per word removed from the buffer.

---
 rtl/credit_pkg.sv | 16 +
 rtl/credit_sink_fifo.sv | 66 ++++++
 rtl/credit_sink.sv | 83 ++++++++
 3 files changed

// File: rtl/credit_pkg.sv
// Shared constants and width helpers for the credit-channel sink.
// The tag bit position and the credit-pipe depth limit are fixed here.
package credit_pkg;

   localparam int TAG_BIT        = 0;
   localparam int MAX_CREDIT_LAT = 3;

   function automatic int sampleWidth(input int dataWidth);
      return dataWidth - 1;
   endfunction

   function automatic int occWidth(input int fifoAddr);
      return fifoAddr + 1;
   endfunction

endpackage

// File: rtl/credit_sink_fifo.sv
// First-word-fall-through buffer for the credit sink.
// Holds storage, wrapping pointers and an occupancy counter one bit wider than the pointers.
module credit_sink_fifo
   import credit_pkg::*;
#(
   parameter int DATA_WIDTH = 17,
   parameter int FIFO_ADDR  = 3,
   parameter int DEPTH      = 2**FIFO_ADDR
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           i_push,
   input  logic                           i_pop,
   input  logic [DATA_WIDTH-1:0]          i_data,
   output logic [DATA_WIDTH-1:0]          o_head,
   output logic [occWidth(FIFO_ADDR)-1:0] o_count,
   output logic                           o_full,
   output logic                           o_empty
);

   localparam int CW = occWidth(FIFO_ADDR);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [2**FIFO_ADDR];
   logic [FIFO_ADDR-1:0]  r_wrPtr;
   logic [FIFO_ADDR-1:0]  r_rdPtr;
   logic [CW-1:0]         r_count;
   logic                  w_doPush;
   logic                  w_doPop;

   // A pop frees the slot in the same cycle, so a push into a full buffer is legal then.
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);

   always_ff @(posedge clock) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rdPtr];
   assign o_count = r_count;
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/credit_sink.sv
// Terminal consumer of the credit channel: buffers tagged words, drops untagged ones,
// presents samples on ready/valid and returns one delayed credit per removed word.
module credit_sink
   import credit_pkg::*;
#(
   parameter int DATA_WIDTH = 17,
   parameter int FIFO_ADDR  = 3,
   parameter int N_CREDITS  = 2**FIFO_ADDR,
   parameter int CREDIT_LAT = 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [DATA_WIDTH-1:0]             i_data,
   input  logic                              i_valid,
   output logic                              o_increment_count,
   output logic [sampleWidth(DATA_WIDTH)-1:0] o_data,
   output logic                              o_valid,
   input  logic                              i_ready,
   output logic [occWidth(FIFO_ADDR)-1:0]    o_count,
   output logic                              o_overflow
);

   localparam int LAT = (CREDIT_LAT > MAX_CREDIT_LAT) ? MAX_CREDIT_LAT : CREDIT_LAT;

   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_tagged;
   logic                  w_pop;
   logic                  r_overflow;

   credit_sink_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_ADDR  (FIFO_ADDR),
      .DEPTH      (N_CREDITS)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (i_valid),
      .i_pop   (w_pop),
      .i_data  (i_data),
      .o_head  (w_head),
      .o_count (o_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Untagged heads leave immediately; tagged heads wait for the downstream handshake.
   assign w_tagged = w_head[TAG_BIT];
   assign w_pop    = !w_empty && (!w_tagged || i_ready);
   assign o_valid  = !w_empty && w_tagged;
   assign o_data   = o_valid ? w_head[DATA_WIDTH-1:1] : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
      end else if (i_valid && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign o_overflow = r_overflow;

   if (LAT == 0) begin : g_creditComb
      assign o_increment_count = w_pop;
   end else begin : g_creditPipe
      logic [LAT-1:0] r_creditPipe;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            r_creditPipe <= '0;
         end else begin
            r_creditPipe[0] <= w_pop;
            for (int i = 1; i < LAT; i++) begin
               r_creditPipe[i] <= r_creditPipe[i-1];
            end
         end
      end

      assign o_increment_count = r_creditPipe[LAT-1];
   end

endmodule
